// File: rtl/hs_toggle_tx.sv
// hs_toggle_tx: source half of a toggle-handshake CDC. Captures one word, flips
// req_tgl, then waits for the synchronized ack level to match before accepting
// the next word. A sticky timeout flags an overdue acknowledge.
module hs_toggle_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_CYCLES   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              req_tgl,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              ack_tgl,
    output logic              done,
    output logic              timeout,
    input  logic              clr_timeout
);

    localparam int unsigned CntW = (TO_CYCLES == 0) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TO_CYCLES);
    localparam bit ToEnable = (TO_CYCLES != 0);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   done_q, done_d;
    logic                   to_q, to_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   accept;

    assign ack_s     = sync_q[SYNC_STAGES-1];
    assign src_ready = (state_q == StIdle);
    assign accept    = src_valid && src_ready;

    assign req_tgl   = req_q;
    assign xfer_data = data_q;
    assign done      = done_q;
    assign timeout   = to_q;

    // Ack synchronizer: the only place ack_tgl is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_tgl};
        end
    end

    // Next-state, capture, completion and timeout logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        to_d    = to_q;

        if (clr_timeout) begin
            to_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Ack changes seen here are a destination protocol error; ignored.
                if (accept) begin
                    data_d  = src_data;
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Set beats a simultaneous clear.
                if (ToEnable && (cnt_q == CntMax)) begin
                    to_d = 1'b1;
                end
                if (ack_s == req_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hs_toggle_tx.sv
// Directed bench for hs_toggle_tx (DATA_W=8, SYNC_STAGES=2, TO_CYCLES=8).
module tb_hs_toggle_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       req_tgl;
    logic [7:0] xfer_data;
    logic       ack_tgl;
    logic       done;
    logic       timeout;
    logic       clr_timeout;

    int errors = 0;
    int checks = 0;

    hs_toggle_tx #(
        .DATA_W(8),
        .SYNC_STAGES(2),
        .TO_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .req_tgl(req_tgl),
        .xfer_data(xfer_data),
        .ack_tgl(ack_tgl),
        .done(done),
        .timeout(timeout),
        .clr_timeout(clr_timeout)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        src_valid   = 1'b0;
        src_data    = 8'h00;
        ack_tgl     = 1'b0;
        clr_timeout = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic accept_word(input logic [7:0] w);
        src_valid = 1'b1;
        src_data  = w;
        step();
        src_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (src_ready !== 1'b1 || req_tgl !== 1'b0 || xfer_data !== 8'h00 ||
            done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b req=%b xfer=%h done=%b to=%b, required 1 0 00 0 0",
                     src_ready, req_tgl, xfer_data, done, timeout);
        end
    endtask

    task automatic test_single();
        logic [3:0] seen;
        do_reset();
        accept_word(8'hA5);
        checks++;
        if (req_tgl !== 1'b1 || xfer_data !== 8'hA5 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: req=%b xfer=%h ready=%b, required 1 a5 0",
                     req_tgl, xfer_data, src_ready);
        end
        ack_tgl = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            seen[i-1] = done;
        end
        checks++;
        if (seen !== 4'b0100) begin
            errors++;
            $display("FAIL single_done_timing: done over E1..E4=%b (E4..E1), required 0100", seen);
        end
        checks++;
        if (src_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after: ready=%b, required 1", src_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic       exp_req [3];
        logic [3:0] hist;
        int         n_acc;
        int         n_done;
        logic       acc;
        logic [7:0] last_x;
        words   = '{8'h01, 8'h02, 8'h03};
        exp_req = '{1'b1, 1'b0, 1'b1};
        do_reset();
        hist      = 4'b0000;
        n_acc     = 0;
        n_done    = 0;
        last_x    = xfer_data;
        src_valid = 1'b1;
        src_data  = words[0];
        for (int cyc = 0; cyc < 80 && n_done < 3; cyc++) begin
            acc = src_ready && src_valid;
            step();
            ack_tgl = hist[3];
            hist    = {hist[2:0], req_tgl};
            if (done === 1'b1) n_done++;
            if (acc) begin
                checks++;
                if (req_tgl !== exp_req[n_acc] || xfer_data !== words[n_acc]) begin
                    errors++;
                    $display("FAIL b2b_accept%0d: req=%b xfer=%h, required %b %h",
                             n_acc, req_tgl, xfer_data, exp_req[n_acc], words[n_acc]);
                end
                n_acc++;
                if (n_acc < 3) src_data = words[n_acc];
                else src_valid = 1'b0;
            end else begin
                checks++;
                if (xfer_data !== last_x) begin
                    errors++;
                    $display("FAIL b2b_stable: xfer=%h, required %h", xfer_data, last_x);
                end
            end
            last_x = xfer_data;
        end
        src_valid = 1'b0;
        checks++;
        if (n_acc != 3 || n_done != 3) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d dones=%0d, required 3 3", n_acc, n_done);
        end
    endtask

    task automatic test_data_hold();
        int got_done;
        do_reset();
        accept_word(8'h3C);
        src_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src_data = 8'hF0 + 8'(i);
            step();
            checks++;
            if (xfer_data !== 8'h3C || req_tgl !== 1'b1 || src_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: xfer=%h req=%b ready=%b, required 3c 1 0",
                         i, xfer_data, req_tgl, src_ready);
            end
        end
        src_valid = 1'b0;
        ack_tgl   = 1'b1;
        got_done  = 0;
        for (int i = 0; i < 10 && got_done == 0; i++) begin
            step();
            if (done === 1'b1) got_done = 1;
        end
        checks++;
        if (got_done != 1) begin
            errors++;
            $display("FAIL hold_done: done seen=%0d, required 1", got_done);
        end
        accept_word(8'h77);
        checks++;
        if (xfer_data !== 8'h77 || req_tgl !== 1'b0) begin
            errors++;
            $display("FAIL hold_next: xfer=%h req=%b, required 77 0", xfer_data, req_tgl);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        accept_word(8'h55);
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early_%0d: timeout=%b, required 0", i, timeout);
            end
        end
        step();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: timeout=%b, required 1", timeout);
        end
        step();
        step();
        checks++;
        if (timeout !== 1'b1 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: timeout=%b ready=%b, required 1 0", timeout, src_ready);
        end
        ack_tgl = 1'b1;
        step();
        step();
        step();
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_late_ack: done=%b timeout=%b, required 1 1", done, timeout);
        end
        clr_timeout = 1'b1;
        step();
        clr_timeout = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b, required 0", timeout);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        accept_word(8'h99);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (src_ready !== 1'b1 || req_tgl !== 1'b0 || xfer_data !== 8'h00 ||
            done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b req=%b xfer=%h done=%b to=%b, required 1 0 00 0 0",
                     src_ready, req_tgl, xfer_data, done, timeout);
        end
        step();
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done !== 1'b0 || src_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_after: bad cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_idle_ack();
        int bad;
        do_reset();
        bad = 0;
        ack_tgl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done !== 1'b0 || src_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_ack: bad cycles=%0d, required 0", bad);
        end
        accept_word(8'h42);
        checks++;
        if (req_tgl !== 1'b1 || xfer_data !== 8'h42) begin
            errors++;
            $display("FAIL idle_ack_accept: req=%b xfer=%h, required 1 42", req_tgl, xfer_data);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        src_valid   = 1'b0;
        src_data    = 8'h00;
        ack_tgl     = 1'b0;
        clr_timeout = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_data_hold();
        test_timeout();
        test_reset_mid();
        test_idle_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_toggle_tx.md
# hs_toggle_tx

Source-side half of the toggle handshake used for multi-bit clock-domain crossings. The block accepts one data word through a valid/ready interface and holds it on a stable bus. It then flips a request toggle and waits for the destination's acknowledge toggle, brought back through a local synchronizer. It sits in the source clock domain, and its `req_tgl` output feeds the destination-domain toggle-to-pulse receiver.

## Interface
- `DATA_W`, default 8: width of transferred word, ≥1.
- `SYNC_STAGES`, default 2: flops in the `ack_tgl` synchronizer, ≥2.
- `TO_CYCLES`, default 1023: WAIT-state cycles before `timeout` sets; 0 disables timeout. Counter width is `$clog2(TO_CYCLES+1)`, minimum 1.

Ports:
- `clk` in 1: source-domain clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `src_valid` in 1: word offered on `src_data`.
- `src_data` in DATA_W: word to transfer.
- `src_ready` out 1: block can accept a word this cycle.
- `req_tgl` out 1: request level; flips once per accepted word.
- `xfer_data` out DATA_W: captured word; stable from accept until the next accept.
- `ack_tgl` in 1: asynchronous acknowledge level from the destination domain.
- `done` out 1: one-cycle pulse when a transfer completes.
- `timeout` out 1: sticky flag, set when an acknowledge is overdue.
- `clr_timeout` in 1: synchronous clear for `timeout`.

## Operation
- States: IDLE, WAIT.
- `src_ready` = (state == IDLE), decoded from the state register.
- **Accept.** An accept occurs on an edge where `src_valid && src_ready`. On that edge:
  - `xfer_data` <= `src_data`.
  - `req_tgl` <= ~`req_tgl`.
  - timeout counter <= 0.
  - state -> WAIT.
- **Ack synchronizer.** `ack_tgl` passes through SYNC_STAGES flops, reset to 0; the last stage is `ack_s`. No other logic samples `ack_tgl`.
- **Completion.** In WAIT, on an edge where `ack_s == req_tgl`:
  - state -> IDLE.
  - `done` <= 1 for exactly one cycle.
- **Timeout.**
  - In WAIT, the counter increments each cycle and saturates at TO_CYCLES.
  - On the edge where the counter equals TO_CYCLES (and TO_CYCLES ≠ 0), `timeout` <= 1.
  - State stays WAIT. A late acknowledge still completes the transfer normally.
- **Timeout clear.** `clr_timeout` clears `timeout`. If a set and `clr_timeout` occur on the same edge, the set wins.
- **Inputs while busy.** `src_valid` while in WAIT is ignored. `src_data` is not sampled in WAIT.
- **Invariant.** `xfer_data` never changes while in WAIT.
- **Protocol consistency.** `req_tgl == ack_s` in IDLE at all times. An `ack_tgl` change seen while in IDLE is a protocol error by the destination. The block ignores it: no state change, no `done`.

## Timing
- Reset values (asynchronous, `rst_n` low):
  - state IDLE, so `src_ready` = 1.
  - `req_tgl` = 0, all sync flops = 0, `xfer_data` = 0.
  - `done` = 0, `timeout` = 0, counter = 0.
- Accept edge to `req_tgl`/`xfer_data` change: 0 cycles (registered, visible immediately after the accept edge).
- `ack_tgl` change to `done` high: SYNC_STAGES+1 edges. With SYNC_STAGES=2, `ack_tgl` flips before edge E1 and `done` is high after E3.
- `src_ready` rises in the same cycle `done` is high.
- **Back-to-back:** with `src_valid` held high, the next word is accepted on the edge that ends the `done` cycle. Throughput is one word per round trip.
- Minimum source-side occupancy per word: 1 (accept) + SYNC_STAGES+1 cycles after the ack change, plus destination latency.
- **Reset mid-transfer:** WAIT is abandoned, `req_tgl` returns to 0, and no `done` is issued. The destination is reset in the same reset domain, so `ack_tgl` returns to 0 and the levels match.
- Completion and a timeout set on the same edge: both take effect (`done` = 1, `timeout` = 1).

## Test plan
- Reset, then `src_valid`=1 with `src_data`=0xA5 for one cycle:
  - `req_tgl` 0->1, `xfer_data`=0xA5, `src_ready`=0.
  - Drive `ack_tgl`=1: `done` high exactly 3 edges later (SYNC_STAGES=2) for 1 cycle, with `src_ready`=1.
- Back-to-back words 0x01, 0x02, 0x03 with `src_valid` held high and a model receiver echoing `req_tgl` after 4 cycles:
  - `req_tgl` sequence 1,0,1.
  - `xfer_data` stable between accepts.
  - 3 `done` pulses; no word lost or duplicated.
- Change `src_data` every cycle while in WAIT: `xfer_data` is unchanged until the next accept.
- TO_CYCLES=8, no acknowledge:
  - `timeout` rises after 8 WAIT cycles and stays set.
  - Flip `ack_tgl`: `done` pulses, `timeout` remains 1.
  - `clr_timeout` clears it.
- Assert `rst_n` low 2 cycles after an accept: all outputs return to reset values, and no `done` is issued afterwards.
- Toggle `ack_tgl` while in IDLE: no `done`, state stays IDLE, and the next accept still flips `req_tgl`.
